// File: rtl/sched_pkg.sv
// sched_pkg: shared constants for the scheduler interrupt controller.
//   - config opcodes (SCHED_OP_SYSVEC .. SCHED_OP_STATS)
//   - handshake FSM state encoding
//   - index of the internal quantum-timer source
package sched_pkg;

  localparam logic [3:0] SCHED_OP_SYSVEC   = 4'd1;
  localparam logic [3:0] SCHED_OP_VEC      = 4'd2;
  localparam logic [3:0] SCHED_OP_MASK     = 4'd3;
  localparam logic [3:0] SCHED_OP_INIT     = 4'd4;
  localparam logic [3:0] SCHED_OP_TMR_RST  = 4'd5;
  localparam logic [3:0] SCHED_OP_SAVE_PC  = 4'd6;
  localparam logic [3:0] SCHED_OP_CUR_PC   = 4'd7;
  localparam logic [3:0] SCHED_OP_QUANTUM  = 4'd8;
  localparam logic [3:0] SCHED_OP_CLR_PEND = 4'd9;
  localparam logic [3:0] SCHED_OP_STATS    = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } sched_state_e;

  localparam int unsigned SCHED_SRC_TIMER = 0;
  localparam int unsigned SCHED_IDX_W     = 4;

endpackage

// File: rtl/sched_prio_arbiter.sv
// sched_prio_arbiter: combinational fixed-priority arbiter, lowest index wins.
// Ports:
//   req_i         eligible sources (pending & ~mask)
//   valid_c_o     at least one source is eligible
//   grant_oh_c_o  one-hot winner
//   grant_idx_c_o encoded winner index
module sched_prio_arbiter
  import sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]     req_i,
  output logic                   valid_c_o,
  output logic [NUM_SRC-1:0]     grant_oh_c_o,
  output logic [SCHED_IDX_W-1:0] grant_idx_c_o
);

  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    valid_c_o     = 1'b0;
    grant_oh_c_o  = '0;
    grant_idx_c_o = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_c_o       = 1'b1;
        grant_oh_c_o    = '0;
        grant_oh_c_o[i] = 1'b1;
        grant_idx_c_o   = SCHED_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sched_irq_ctrl.sv
// sched_irq_ctrl: multi-source interrupt controller for the scheduler.
// Source 0 is an internal quantum timer, sources 1..NUM_SRC-1 are rising-edge
// external lines. Fixed-priority arbitration feeds a req/ack/iret handshake.
// Optional macro SCHED_STATS_EN adds per-source 16-bit saturating grant
// counters readable through op 10.
// Ports:
//   clock, reset         clock, async active-high reset
//   kernel_mode          suppresses new requests
//   pc_pos, prg_enb      current PC and its valid strobe
//   ext_irq              external lines, bit i -> source i+1
//   cfg_en/op/idx/value  config instruction
//   int_req/src/pos      request, winning source and its vector
//   int_ack, iret        core handshake
//   sys_int_pos          syscall vector
//   wr_flag/addr/data    register-file write port
module sched_irq_ctrl
  import sched_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned PC_W        = 16,
  parameter int unsigned TMR_W       = 32,
  parameter int unsigned QUANTUM_DEF = 500000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               kernel_mode,
  input  logic [PC_W-1:0]    pc_pos,
  input  logic               prg_enb,
  input  logic [NUM_SRC-2:0] ext_irq,
  input  logic               cfg_en,
  input  logic [3:0]         cfg_op,
  input  logic [3:0]         cfg_idx,
  input  logic [15:0]        cfg_value,
  output logic               int_req,
  output logic [3:0]         int_src,
  output logic [PC_W-1:0]    int_pos,
  input  logic               int_ack,
  input  logic               iret,
  output logic [PC_W-1:0]    sys_int_pos,
  output logic               wr_flag,
  output logic [7:0]         wr_addr,
  output logic [31:0]        wr_data
);

  sched_state_e                  state_q, state_d;
  logic [NUM_SRC-1:0][PC_W-1:0]  vector_q, vector_d;
  logic [NUM_SRC-1:0]            mask_q, mask_d;
  logic [NUM_SRC-1:0]            pending_q, pending_d;
  logic                          init_q, init_d;
  logic [TMR_W-1:0]              timer_q, timer_d;
  logic [TMR_W-1:0]              quantum_q, quantum_d;
  logic [PC_W-1:0]               saved_pc_q, saved_pc_d;
  logic [NUM_SRC-2:0]            ext_q;
  logic                          int_req_q, int_req_d;
  logic [3:0]                    int_src_q, int_src_d;
  logic [PC_W-1:0]               int_pos_q, int_pos_d;
  logic [PC_W-1:0]               sys_int_pos_q, sys_int_pos_d;
  logic                          wr_flag_q, wr_flag_d;
  logic [7:0]                    wr_addr_q, wr_addr_d;
  logic [31:0]                   wr_data_q, wr_data_d;

  logic [NUM_SRC-2:0]            ext_rise;
  logic                          timer_exp;
  logic                          op_tmr_rst;
  logic [NUM_SRC-1:0]            pend_set, pend_clr;
  logic                          arb_valid;
  logic [NUM_SRC-1:0]            arb_oh;
  logic [3:0]                    arb_idx;
  logic [PC_W-1:0]               arb_vec;

`ifdef SCHED_STATS_EN
  logic [NUM_SRC-1:0][15:0]      cnt_q, cnt_d;
  logic [15:0]                   cnt_rd;
  logic                          idx_ok;
`endif

  sched_prio_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req_i         (pending_q & ~mask_q),
    .valid_c_o     (arb_valid),
    .grant_oh_c_o  (arb_oh),
    .grant_idx_c_o (arb_idx)
  );

  // Event detection: timer expiry, external rising edges; op 5 beats expiry.
  assign ext_rise   = ext_irq & ~ext_q;
  assign timer_exp  = init_q && (timer_q == (quantum_q - TMR_W'(1)));
  assign op_tmr_rst = cfg_en && (cfg_op == SCHED_OP_TMR_RST);
  assign pend_set   = {ext_rise, timer_exp & ~op_tmr_rst};

  // Vector of the current arbitration winner.
  always_comb begin
    arb_vec = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (arb_oh[i]) arb_vec = vector_q[i];
    end
  end

`ifdef SCHED_STATS_EN
  assign idx_ok = ({1'b0, cfg_idx} < 5'(NUM_SRC));

  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (4'(i) == cfg_idx) cnt_rd = cnt_q[i];
    end
  end
`endif

  // Next-state: FSM, timer, pending, config and write port.
  always_comb begin
    state_d       = state_q;
    vector_d      = vector_q;
    mask_d        = mask_q;
    init_d        = init_q;
    timer_d       = timer_q;
    quantum_d     = quantum_q;
    saved_pc_d    = saved_pc_q;
    int_req_d     = int_req_q;
    int_src_d     = int_src_q;
    int_pos_d     = int_pos_q;
    sys_int_pos_d = sys_int_pos_q;
    wr_flag_d     = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    pend_clr      = '0;
`ifdef SCHED_STATS_EN
    cnt_d         = cnt_q;
`endif

    if (op_tmr_rst) begin
      timer_d                   = '0;
      pend_clr[SCHED_SRC_TIMER] = 1'b1;
    end else if (init_q) begin
      timer_d = timer_exp ? '0 : timer_q + TMR_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (init_q && !kernel_mode && arb_valid) begin
          state_d   = ST_REQ;
          int_req_d = 1'b1;
          int_src_d = arb_idx;
          int_pos_d = arb_vec;
        end
      end
      // int_src/int_pos stay frozen until the core acknowledges.
      ST_REQ: begin
        if (int_ack) begin
          state_d   = ST_SERVICE;
          int_req_d = 1'b0;
          if (prg_enb) saved_pc_d = pc_pos;
          for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (4'(i) == int_src_q) begin
              pend_clr[i] = 1'b1;
`ifdef SCHED_STATS_EN
              if (cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
`endif
            end
          end
        end
      end
      ST_SERVICE: begin
        if (iret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_en) begin
      case (cfg_op)
        SCHED_OP_SYSVEC: sys_int_pos_d = PC_W'(cfg_value);
        SCHED_OP_VEC: begin
          for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (4'(i) == cfg_idx) vector_d[i] = PC_W'(cfg_value);
          end
        end
        SCHED_OP_MASK: begin
          for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (4'(i) == cfg_idx) mask_d[i] = cfg_value[0];
          end
        end
        SCHED_OP_INIT: init_d = 1'b1;
        SCHED_OP_SAVE_PC: begin
          wr_flag_d = 1'b1;
          wr_addr_d = cfg_value[7:0];
          wr_data_d = 32'(saved_pc_q);
        end
        SCHED_OP_CUR_PC: begin
          wr_flag_d = 1'b1;
          wr_addr_d = cfg_value[7:0];
          wr_data_d = 32'(pc_pos);
        end
        // A zero quantum would never expire; clamp it to 1.
        SCHED_OP_QUANTUM: quantum_d = (cfg_value == 16'd0) ? TMR_W'(1) : TMR_W'(cfg_value);
        SCHED_OP_CLR_PEND: begin
          for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (4'(i) == cfg_idx) pend_clr[i] = 1'b1;
          end
        end
`ifdef SCHED_STATS_EN
        SCHED_OP_STATS: begin
          if (idx_ok) begin
            wr_flag_d = 1'b1;
            wr_addr_d = cfg_value[7:0];
            wr_data_d = {16'b0, cnt_rd};
          end
        end
`endif
        default: ;
      endcase
    end

    // A new event in the same cycle as a clear keeps the source pending.
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      vector_q      <= '0;
      mask_q        <= '1;
      pending_q     <= '0;
      init_q        <= 1'b0;
      timer_q       <= '0;
      quantum_q     <= TMR_W'(QUANTUM_DEF);
      saved_pc_q    <= '0;
      ext_q         <= '0;
      int_req_q     <= 1'b0;
      int_src_q     <= '0;
      int_pos_q     <= '0;
      sys_int_pos_q <= '0;
      wr_flag_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      vector_q      <= vector_d;
      mask_q        <= mask_d;
      pending_q     <= pending_d;
      init_q        <= init_d;
      timer_q       <= timer_d;
      quantum_q     <= quantum_d;
      saved_pc_q    <= saved_pc_d;
      ext_q         <= ext_irq;
      int_req_q     <= int_req_d;
      int_src_q     <= int_src_d;
      int_pos_q     <= int_pos_d;
      sys_int_pos_q <= sys_int_pos_d;
      wr_flag_q     <= wr_flag_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign int_req     = int_req_q;
  assign int_src     = int_src_q;
  assign int_pos     = int_pos_q;
  assign sys_int_pos = sys_int_pos_q;
  assign wr_flag     = wr_flag_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_sched_irq_ctrl.sv
// Directed self-checking bench for sched_irq_ctrl (default parameters).
module tb_sched_irq_ctrl;

  logic        clock;
  logic        reset;
  logic        kernel_mode;
  logic [15:0] pc_pos;
  logic        prg_enb;
  logic [2:0]  ext_irq;
  logic        cfg_en;
  logic [3:0]  cfg_op;
  logic [3:0]  cfg_idx;
  logic [15:0] cfg_value;
  logic        int_req;
  logic [3:0]  int_src;
  logic [15:0] int_pos;
  logic        int_ack;
  logic        iret;
  logic [15:0] sys_int_pos;
  logic        wr_flag;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  sched_irq_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .kernel_mode (kernel_mode),
    .pc_pos      (pc_pos),
    .prg_enb     (prg_enb),
    .ext_irq     (ext_irq),
    .cfg_en      (cfg_en),
    .cfg_op      (cfg_op),
    .cfg_idx     (cfg_idx),
    .cfg_value   (cfg_value),
    .int_req     (int_req),
    .int_src     (int_src),
    .int_pos     (int_pos),
    .int_ack     (int_ack),
    .iret        (iret),
    .sys_int_pos (sys_int_pos),
    .wr_flag     (wr_flag),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] op, input logic [3:0] idx, input logic [15:0] val);
    cfg_en = 1'b1; cfg_op = op; cfg_idx = idx; cfg_value = val;
    tick();
    cfg_en = 1'b0; cfg_op = 4'd0; cfg_idx = 4'd0; cfg_value = 16'd0;
  endtask

  task automatic apply_reset();
    kernel_mode = 1'b0; pc_pos = 16'd0; prg_enb = 1'b0; ext_irq = 3'b000;
    cfg_en = 1'b0; cfg_op = 4'd0; cfg_idx = 4'd0; cfg_value = 16'd0;
    int_ack = 1'b0; iret = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    kernel_mode = 1'b0; pc_pos = 16'd0; prg_enb = 1'b0; ext_irq = 3'b000;
    cfg_en = 1'b0; cfg_op = 4'd0; cfg_idx = 4'd0; cfg_value = 16'd0;
    int_ack = 1'b0; iret = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req: got %b want 0", int_req); end
    n_checks++; if (int_src !== 4'd0) begin n_fail++; $display("FAIL reset_int_src: got %h want 0", int_src); end
    n_checks++; if (int_pos !== 16'd0) begin n_fail++; $display("FAIL reset_int_pos: got %h want 0", int_pos); end
    n_checks++; if (sys_int_pos !== 16'd0) begin n_fail++; $display("FAIL reset_sys_int_pos: got %h want 0", sys_int_pos); end
    n_checks++; if (wr_flag !== 1'b0) begin n_fail++; $display("FAIL reset_wr_flag: got %b want 0", wr_flag); end
    n_checks++; if (wr_addr !== 8'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    n_checks++; if (wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    tick();
    reset = 1'b0;
  endtask

  // Timer source end to end, then ack with PC save and op 6 write-back.
  task automatic test_quantum_handshake();
    int n;
    apply_reset();
    do_cfg(4'd8, 4'd0, 16'd10);
    do_cfg(4'd3, 4'd0, 16'd0);
    do_cfg(4'd2, 4'd0, 16'h0040);
    do_cfg(4'd1, 4'd0, 16'hABCD);
    n_checks++; if (sys_int_pos !== 16'hABCD) begin n_fail++; $display("FAIL sysvec: got %h want abcd", sys_int_pos); end
    do_cfg(4'd4, 4'd0, 16'd0);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (int_req === 1'b1) begin n = k; break; end
    end
    n_checks++; if (n < 11 || n > 12) begin n_fail++; $display("FAIL quantum_latency: got %0d cycles want 11..12", n); end
    n_checks++; if (int_src !== 4'd0) begin n_fail++; $display("FAIL quantum_src: got %h want 0", int_src); end
    n_checks++; if (int_pos !== 16'h0040) begin n_fail++; $display("FAIL quantum_pos: got %h want 0040", int_pos); end
    pc_pos = 16'h1234; prg_enb = 1'b1; int_ack = 1'b1;
    tick();
    pc_pos = 16'h0000; prg_enb = 1'b0; int_ack = 1'b0;
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL ack_drop_req: got %b want 0", int_req); end
    do_cfg(4'd6, 4'd0, 16'h0005);
    n_checks++; if (wr_flag !== 1'b1) begin n_fail++; $display("FAIL op6_flag: got %b want 1", wr_flag); end
    n_checks++; if (wr_addr !== 8'h05) begin n_fail++; $display("FAIL op6_addr: got %h want 05", wr_addr); end
    n_checks++; if (wr_data !== 32'h0000_1234) begin n_fail++; $display("FAIL op6_data: got %h want 00001234", wr_data); end
    tick();
    n_checks++; if (wr_flag !== 1'b0) begin n_fail++; $display("FAIL op6_pulse: got %b want 0", wr_flag); end
    n_checks++; if (wr_addr !== 8'h05) begin n_fail++; $display("FAIL op6_addr_hold: got %h want 05", wr_addr); end
    // Timer re-expires during the handler; no request may be issued.
    for (int k = 0; k < 12; k++) tick();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL service_no_req: got %b want 0", int_req); end
    iret = 1'b1;
    tick();
    iret = 1'b0;
    tick();
    n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL after_iret_req: got %b want 1", int_req); end
  endtask

  task automatic test_priority();
    apply_reset();
    do_cfg(4'd3, 4'd1, 16'd0);
    do_cfg(4'd3, 4'd2, 16'd0);
    do_cfg(4'd2, 4'd1, 16'h0100);
    do_cfg(4'd2, 4'd2, 16'h0200);
    do_cfg(4'd4, 4'd0, 16'd0);
    ext_irq = 3'b011;
    tick();
    tick();
    n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %b want 1", int_req); end
    n_checks++; if (int_src !== 4'd1) begin n_fail++; $display("FAIL prio_first_src: got %h want 1", int_src); end
    n_checks++; if (int_pos !== 16'h0100) begin n_fail++; $display("FAIL prio_first_pos: got %h want 0100", int_pos); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL prio_gap: got %b want 0", int_req); end
    tick();
    n_checks++; if (int_src !== 4'd2) begin n_fail++; $display("FAIL prio_second_src: got %h want 2", int_src); end
    n_checks++; if (int_pos !== 16'h0200) begin n_fail++; $display("FAIL prio_second_pos: got %h want 0200", int_pos); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    // Lines still held high: no further events.
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL level_one_event: got %b want 0", int_req); end
    ext_irq = 3'b000;
    do_cfg(4'd10, 4'd1, 16'h0033);
`ifdef SCHED_STATS_EN
    n_checks++; if (wr_flag !== 1'b1 || wr_data !== 32'd1) begin n_fail++; $display("FAIL stats_src1: got flag %b data %h want 1 00000001", wr_flag, wr_data); end
`else
    n_checks++; if (wr_flag !== 1'b0) begin n_fail++; $display("FAIL op10_noop: got %b want 0", wr_flag); end
`endif
  endtask

  task automatic test_gating();
    int n;
    apply_reset();
    do_cfg(4'd3, 4'd1, 16'd0);
    do_cfg(4'd3, 4'd2, 16'd0);
    do_cfg(4'd2, 4'd1, 16'h0100);
    do_cfg(4'd2, 4'd2, 16'h0200);
    do_cfg(4'd4, 4'd0, 16'd0);
    kernel_mode = 1'b1;
    ext_irq = 3'b010; tick(); ext_irq = 3'b000;
    for (int k = 0; k < 5; k++) tick();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL kernel_gate: got %b want 0", int_req); end
    kernel_mode = 1'b0;
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (int_req === 1'b1) begin n = k; break; end
    end
    n_checks++; if (n < 1 || n > 2) begin n_fail++; $display("FAIL kernel_release: got %0d cycles want 1..2", n); end
    // Higher-priority arrival while in REQ must not disturb the outputs.
    ext_irq = 3'b001; tick(); ext_irq = 3'b000;
    tick(); tick();
    n_checks++; if (int_src !== 4'd2 || int_pos !== 16'h0200 || int_req !== 1'b1) begin
      n_fail++; $display("FAIL req_hold: got req %b src %h pos %h want 1 2 0200", int_req, int_src, int_pos);
    end
    iret = 1'b1; tick(); iret = 1'b0;
    n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL iret_in_req: got %b want 1", int_req); end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
    n_checks++; if (int_src !== 4'd1 || int_req !== 1'b1) begin n_fail++; $display("FAIL deferred_src1: got req %b src %h want 1 1", int_req, int_src); end
  endtask

  task automatic test_collisions();
    int n;
    apply_reset();
    do_cfg(4'd3, 4'd1, 16'd0);
    do_cfg(4'd2, 4'd1, 16'h0100);
    do_cfg(4'd4, 4'd0, 16'd0);
    ext_irq = 3'b001; tick(); ext_irq = 3'b000;
    tick();
    n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL coll_req: got %b want 1", int_req); end
    int_ack = 1'b1; ext_irq = 3'b001; tick(); int_ack = 1'b0; ext_irq = 3'b000;
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
    n_checks++; if (int_req !== 1'b1 || int_src !== 4'd1) begin n_fail++; $display("FAIL set_beats_ack: got req %b src %h want 1 1", int_req, int_src); end

    apply_reset();
    do_cfg(4'd8, 4'd0, 16'd10);
    do_cfg(4'd3, 4'd0, 16'd0);
    do_cfg(4'd4, 4'd0, 16'd0);
    for (int k = 0; k < 9; k++) tick();
    do_cfg(4'd5, 4'd0, 16'd0);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (int_req === 1'b1) begin n = k; break; end
    end
    n_checks++; if (n != 11) begin n_fail++; $display("FAIL op5_on_expiry: req after %0d cycles want 11", n); end
  endtask

  task automatic test_quantum_zero_and_op7();
    int n;
    apply_reset();
    do_cfg(4'd8, 4'd0, 16'd0);
    do_cfg(4'd3, 4'd0, 16'd0);
    do_cfg(4'd4, 4'd0, 16'd0);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (int_req === 1'b1) begin n = k; break; end
    end
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL quantum_zero: req after %0d cycles want 2", n); end
    pc_pos = 16'hBEEF;
    do_cfg(4'd7, 4'd0, 16'h0022);
    pc_pos = 16'h0000;
    n_checks++; if (wr_flag !== 1'b1 || wr_addr !== 8'h22 || wr_data !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL op7_write: got %b %h %h want 1 22 0000beef", wr_flag, wr_addr, wr_data);
    end
    tick();
    n_checks++; if (wr_flag !== 1'b0 || wr_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL op7_hold: got %b %h want 0 0000beef", wr_flag, wr_data); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_cfg(4'd1, 4'd0, 16'h0077);
    do_cfg(4'd3, 4'd1, 16'd0);
    do_cfg(4'd2, 4'd1, 16'h0100);
    do_cfg(4'd4, 4'd0, 16'd0);
    ext_irq = 3'b001; tick(); ext_irq = 3'b000;
    tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    n_checks++; if (int_src !== 4'd1 || int_pos !== 16'h0100) begin n_fail++; $display("FAIL pre_reset_state: got src %h pos %h want 1 0100", int_src, int_pos); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (int_src !== 4'd0 || int_pos !== 16'd0 || sys_int_pos !== 16'd0 || int_req !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got req %b src %h pos %h sys %h want all 0", int_req, int_src, int_pos, sys_int_pos);
    end
    tick();
    reset = 1'b0;
    do_cfg(4'd4, 4'd0, 16'd0);
    ext_irq = 3'b001; tick(); ext_irq = 3'b000;
    tick(); tick(); tick();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_after_reset: got %b want 0", int_req); end
    do_cfg(4'd3, 4'd1, 16'd0);
    tick();
    n_checks++; if (int_req !== 1'b1 || int_src !== 4'd1 || int_pos !== 16'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got req %b src %h pos %h want 1 1 0000", int_req, int_src, int_pos);
    end
  endtask

  initial begin
    test_reset();
    test_quantum_handshake();
    test_priority();
    test_gating();
    test_collisions();
    test_quantum_zero_and_op7();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sched_irq_ctrl.md
Name: sched_irq_ctrl

Overview:
Parametrised successor to the single-timer scheduler. It has NUM_SRC interrupt sources: source 0 is an internal quantum timer and sources 1..NUM_SRC-1 are external edge-triggered lines such as DMA-done. Each source has its own vector, mask and pending bit, a fixed-priority arbiter picks among them, and a req/ack/iret handshake drives the core. The block sits between the scheduler instruction decoder and the PC/fetch unit, and writes saved PCs back to the register file.

Parameters:
NUM_SRC, 4, number of interrupt sources (2..16); source 0 is the timer.
PC_W, 16, PC and vector width.
TMR_W, 32, quantum timer width.
QUANTUM_DEF, 500000, quantum reload value after reset.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
kernel_mode  in  1  core is in kernel mode; no interrupts are requested
pc_pos  in  PC_W  current PC
prg_enb  in  1  pc_pos is valid this cycle
ext_irq  in  NUM_SRC-1  external lines; bit i maps to source i+1
cfg_en  in  1  config instruction strobe
cfg_op  in  4  config opcode
cfg_idx  in  4  source index for per-source ops
cfg_value  in  16  config operand
int_req  out  1  interrupt request to the core
int_src  out  4  index of the winning source
int_pos  out  PC_W  vector of the winning source
int_ack  in  1  core accepts the request
iret  in  1  core returns from the handler
sys_int_pos  out  PC_W  syscall vector
wr_flag  out  1  register-file write strobe
wr_addr  out  8  register-file write address
wr_data  out  32  register-file write data, PC zero-extended

Behaviour:
- Reset (async) values:
  - Outputs int_req, int_src, int_pos, sys_int_pos, wr_flag, wr_addr and wr_data are all 0.
  - Internal state: vectors 0, mask all 1 (masked), pending 0, initialized 0, timer 0, quantum QUANTUM_DEF, saved_pc 0, FSM in IDLE.
- Timer:
  - Counts +1 per clock while initialized=1.
  - When count equals quantum-1, sets pending[0] and wraps to 0.
  - Op 5 in the same cycle as expiry: the reset wins, the count goes to 0 and pending[0] is cleared.
- External sources:
  - Each line has a rising-edge detector (one registered stage) that sets pending[i+1].
  - A level held high produces only one event.
- Pending set vs clear in the same cycle (from ack or op 9): the set wins.
- Arbiter:
  - Eligible sources are pending and unmasked.
  - The lowest index wins.
  - Arbitration runs only when FSM=IDLE, initialized=1 and kernel_mode=0.
- FSM:
  - IDLE -> REQ when an eligible source exists. Next cycle: int_req=1, int_src and int_pos latched.
  - REQ: outputs are held stable until int_ack, even if a higher-priority source becomes pending.
  - REQ -> SERVICE on int_ack. Same edge: clear pending[int_src], capture saved_pc=pc_pos (if prg_enb=1), drop int_req.
  - SERVICE -> IDLE on iret. No request is issued in SERVICE.
  - int_ack outside REQ and iret outside SERVICE are ignored.
- Config ops (take effect when cfg_en=1):
  - 1: sys_int_pos = cfg_value.
  - 2: vector[cfg_idx] = cfg_value.
  - 3: mask[cfg_idx] = cfg_value[0].
  - 4: initialized = 1.
  - 5: timer = 0 and pending[0] = 0.
  - 6: write saved_pc to wr_addr = cfg_value[7:0].
  - 7: write pc_pos to wr_addr = cfg_value[7:0].
  - 8: quantum = cfg_value zero-extended; a value of 0 is treated as 1.
  - 9: pending[cfg_idx] = 0.
  - cfg_idx >= NUM_SRC and undefined ops are no-ops.
- Write port: wr_flag is a 1-cycle pulse registered the cycle after op 6/7. wr_addr and wr_data hold their last value.

Optional Feature:
SCHED_STATS_EN:
- With the macro defined:
  - Each source has a 16-bit saturating counter, incremented on int_ack for that source and cleared by reset.
  - Op 10 writes {16'b0, count[cfg_idx]} to wr_addr = cfg_value[7:0] using the same one-cycle pulse as ops 6/7.
- Without it: no counters exist and op 10 is a no-op.

Decomposition:
- Package sched_pkg:
  - cfg opcode localparams (SCHED_OP_SYSVEC..SCHED_OP_STATS).
  - FSM state enum {IDLE, REQ, SERVICE}.
  - Source-0 index constant.
- Sub-module sched_prio_arbiter: combinational, takes pending & ~mask, outputs valid plus the lowest-index one-hot/encoded winner. Parametrised by NUM_SRC.

Test Plan:
- Quantum: reset; op 8 value 10; unmask source 0; op 4; kernel_mode=0 -> int_req rises 11 or 12 cycles after op 4, int_src=0, int_pos equal to vector[0]=0x0040.
- Priority: pending on sources 2 and 1 in the same cycle, both unmasked -> source 1 granted first; after ack and iret, source 2 granted.
- Handshake/PC save: in REQ, assert int_ack with pc_pos=0x1234 -> SERVICE; op 6 value 0x05 -> one-cycle wr_flag, wr_addr=0x05, wr_data=0x00001234.
- Gating: kernel_mode=1 with source 1 pending -> no int_req; drop kernel_mode -> int_req within 2 cycles.
- Collisions: op 5 on the timer expiry cycle -> no pending[0], timer=0. ext_irq edge on the same cycle as the ack of that source -> pending stays 1.
- Reset mid-operation: assert reset in SERVICE -> all outputs 0 immediately, FSM in IDLE, mask all 1.
